sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
Parametrised, registered bridge between the processor's memory-request side and an external asynchronous SRAM. Accepts one read or write request at a time and generates correctly sequenced active-low CE/OE/WE/byte strobes with configurable wait states. Captures read data and signals completion with a single-cycle Ready pulse. Replaces hard-wired Mem_CE/UB/LB/OE/WE control, generalising data width, address width and timing.

Parameters:
DW, 16, data width in bits; must be a multiple of 8; NB = DW/8 byte lanes
AW, 20, SRAM address width
WAIT_RD, 2, cycles OE is held low per read; legal range 1..15
WAIT_WR, 2, cycles WE is held low per write; legal range 1..15

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Req  in  1  request strobe; sampled only in IDLE
Wr  in  1  1 = write, 0 = read; sampled with Req
Byte_En  in  NB  active-high lane enables; bit i covers data[8i+7:8i]
Addr  in  AW  access address; sampled with Req
Wdata  in  DW  write data; sampled with Req
Rdata  out  DW  captured read data; holds until the next read completes
Ready  out  1  one-cycle completion pulse
Busy  out  1  high whenever state != IDLE
Mem_Addr  out  AW  registered SRAM address
Mem_Data  inout  DW  SRAM data bus; driven only during write phases, otherwise high-Z
Mem_CE_N, Mem_OE_N, Mem_WE_N  out  1 each  active-low SRAM strobes
Mem_BE_N  out  NB  active-low byte strobes (UB/LB for DW=16)

Behaviour:
- Reset (asynchronous, immediate): state IDLE; Rdata=0; Ready=0; Busy=0; Mem_Addr=0; CE_N=OE_N=WE_N=1; BE_N all 1; Mem_Data high-Z; wait counter 0. Reset mid-access aborts without completing it or pulsing Ready.
- All strobes and Mem_Addr are registered outputs. No combinational path from inputs to SRAM pins.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: on a rising edge with Req=1, latch Wr, Addr, Wdata and Byte_En.
  - Byte_En == 0: go to DONE. No strobes asserted; Rdata unchanged.
  - Otherwise, read: go to RD. Write: go to WR_SETUP.
- RD: CE_N=0, OE_N=0, BE_N=~Byte_En for exactly WAIT_RD cycles. On the edge ending the last RD cycle, enabled lanes of Rdata load from Mem_Data; disabled lanes load 0. Then go to DONE.
- WR_SETUP (1 cycle): CE_N=0, WE_N=1, BE_N active, Mem_Data driven with latched Wdata.
- WR_PULSE (WAIT_WR cycles): WE_N=0; other signals as in WR_SETUP.
- WR_HOLD (1 cycle): WE_N=1; data, CE_N and BE_N still driven.
- DONE (1 cycle): Ready=1; all strobes deasserted; Mem_Data high-Z (bus turnaround). Then go to IDLE.
- Latency from the accepting edge to the Ready cycle:
  - read: WAIT_RD+1 cycles
  - write: WAIT_WR+3 cycles
  - zero-enable request: 1 cycle
- Back-to-back: minimum one IDLE cycle between Ready and the next acceptance.
- Req outside IDLE is ignored and not queued. Input changes after acceptance have no effect.
- Invariants:
  - OE_N and WE_N are never both 0.
  - Mem_Data is never driven while OE_N=0.
  - Mem_Addr is stable from the first strobe through DONE.

Test Plan:
1. Reset asserted mid-cycle -> all outputs at reset values immediately; Mem_Data=Z; Busy=0.
2. DW=16, WAIT_RD=2: Req, Wr=0, Addr=0x00123, Byte_En=2'b11; SRAM model returns 0xBEEF -> OE_N low for 2 cycles; Ready in cycle 3 after acceptance; Rdata=0xBEEF.
3. WAIT_WR=2: write Addr=0x00040, Wdata=0x1234, Byte_En=2'b11 -> WE_N low exactly 2 cycles, bracketed by 1 setup and 1 hold cycle with data driven; Ready in cycle 5; model memory holds 0x1234.
4. Read with Byte_En=2'b10 at a location holding 0xABCD -> Mem_BE_N=2'b01; Rdata=0xAB00. Then write with Byte_En=2'b01, Wdata=0x0055 -> memory=0xAB55.
5. Req with Byte_En=0 -> no strobe toggles; Ready the next cycle; Rdata unchanged. Req pulsed while Busy=1 -> ignored; exactly one Ready per accepted request.
6. Reset asserted during WR_PULSE -> WE_N=1 and Mem_Data=Z immediately; no Ready pulse. A post-reset read completes normally.
7. Assertions throughout all scenarios: OE_N and WE_N never simultaneously low; Mem_Data never driven while OE_N=0.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Registered bridge from a single-request memory port to an asynchronous SRAM.
// Sequences CE/OE/WE/byte strobes with programmable read and write pulse widths.
module sram_access_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 20,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic            Wr,
    input  logic [DW/8-1:0] Byte_En,
    input  logic [AW-1:0]   Addr,
    input  logic [DW-1:0]   Wdata,
    output logic [DW-1:0]   Rdata,
    output logic            Ready,
    output logic            Busy,
    output logic [AW-1:0]   Mem_Addr,
    inout  wire  [DW-1:0]   Mem_Data,
    output logic            Mem_CE_N,
    output logic            Mem_OE_N,
    output logic            Mem_WE_N,
    output logic [DW/8-1:0] Mem_BE_N
);

    localparam int NB = DW / 8;
    localparam logic [3:0] RD_CNT = 4'(WAIT_RD - 1);
    localparam logic [3:0] WR_CNT = 4'(WAIT_WR - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic [NB-1:0]   be_q;
    logic [NB-1:0]   be_nxt;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rd_masked;
    logic            drive;
    logic            active;
    logic            wr_phase;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        be_nxt  = be_q;
        unique case (state)
            IDLE: begin
                if (Req) begin
                    be_nxt = Byte_En;
                    if (Byte_En == '0) begin
                        nxt = DONE;
                    end else if (Wr) begin
                        nxt = WR_SETUP;
                    end else begin
                        nxt     = RD;
                        cnt_nxt = RD_CNT;
                    end
                end
            end
            RD: begin
                if (cnt == 4'd0) nxt = DONE;
                else cnt_nxt = cnt - 4'd1;
            end
            WR_SETUP: begin
                nxt     = WR_PULSE;
                cnt_nxt = WR_CNT;
            end
            WR_PULSE: begin
                if (cnt == 4'd0) nxt = WR_HOLD;
                else cnt_nxt = cnt - 4'd1;
            end
            WR_HOLD: nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the pins come straight from flops.
    always_comb begin
        wr_phase = (nxt == WR_SETUP) || (nxt == WR_PULSE) || (nxt == WR_HOLD);
        active   = wr_phase || (nxt == RD);
    end

    always_comb begin
        rd_masked = '0;
        for (int i = 0; i < NB; i++) begin
            if (be_q[i]) rd_masked[8*i +: 8] = Mem_Data[8*i +: 8];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            be_q     <= '0;
            wdata_q  <= '0;
            Rdata    <= '0;
            Ready    <= 1'b0;
            Busy     <= 1'b0;
            Mem_Addr <= '0;
            Mem_CE_N <= 1'b1;
            Mem_OE_N <= 1'b1;
            Mem_WE_N <= 1'b1;
            Mem_BE_N <= '1;
            drive    <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= cnt_nxt;
            be_q     <= be_nxt;
            Ready    <= (nxt == DONE);
            Busy     <= (nxt != IDLE);
            Mem_CE_N <= !active;
            Mem_OE_N <= (nxt != RD);
            Mem_WE_N <= (nxt != WR_PULSE);
            Mem_BE_N <= active ? ~be_nxt : '1;
            drive    <= wr_phase;
            if (state == IDLE && Req) begin
                Mem_Addr <= Addr;
                wdata_q  <= Wdata;
            end
            if (state == RD && cnt == 4'd0) Rdata <= rd_masked;
        end
    end

    assign Mem_Data = drive ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: directed vector table, reset-abort sequences
// and random traffic against a word-level SRAM reference model.
module tb_sram_access_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 20;
    localparam int WRD = 2;
    localparam int WWR = 2;

    logic          Clk;
    logic          Reset;
    logic          Req;
    logic          Wr;
    logic [1:0]    Byte_En;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Wdata;
    logic [DW-1:0] Rdata;
    logic          Ready;
    logic          Busy;
    logic [AW-1:0] Mem_Addr;
    wire  [DW-1:0] mem_data;
    logic          Mem_CE_N;
    logic          Mem_OE_N;
    logic          Mem_WE_N;
    logic [1:0]    Mem_BE_N;

    sram_access_ctrl #(
        .DW(DW), .AW(AW), .WAIT_RD(WRD), .WAIT_WR(WWR)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr),
        .Byte_En(Byte_En), .Addr(Addr), .Wdata(Wdata),
        .Rdata(Rdata), .Ready(Ready), .Busy(Busy),
        .Mem_Addr(Mem_Addr), .Mem_Data(mem_data),
        .Mem_CE_N(Mem_CE_N), .Mem_OE_N(Mem_OE_N),
        .Mem_WE_N(Mem_WE_N), .Mem_BE_N(Mem_BE_N)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_word(input logic [10:0] i);
        if (i == 11'h123) return 16'hBEEF;
        if (i == 11'h077) return 16'hABCD;
        return {i[7:0] ^ 8'h5A, i[10:3] ^ 8'hC3};
    endfunction

    // Asynchronous SRAM model
    logic [15:0] sram [0:2047];
    bit          loaded;

    always @(negedge Clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) sram[i] = init_word(11'(i));
            loaded = 1'b1;
        end
        if (!Mem_CE_N && !Mem_WE_N) begin
            for (int i = 0; i < 2; i++) begin
                if (!Mem_BE_N[i]) sram[Mem_Addr[10:0]][8*i +: 8] = mem_data[8*i +: 8];
            end
        end
    end

    assign mem_data = (!Mem_CE_N && !Mem_OE_N) ? sram[Mem_Addr[10:0]] : 16'hzzzz;

    assert property (@(posedge Clk) disable iff (Reset) !(!Mem_OE_N && !Mem_WE_N))
        else $error("FAIL inv_oe_we: OE_N and WE_N both low");

    // Reference model state
    logic [15:0] ref_mem [0:2047];
    logic [15:0] exp_rdata;
    int          tests;
    int          errors;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic wr, input logic [1:0] be);
        if (be == 2'b00) return 1;
        return wr ? WWR + 3 : WRD + 1;
    endfunction

    // Applies a request to the model; returns the word expected in memory afterwards.
    function automatic logic [15:0] model_apply(input logic wr, input logic [10:0] a,
                                                input logic [15:0] wd, input logic [1:0] be);
        logic [15:0] w;
        w = ref_mem[a];
        if (be != 2'b00) begin
            if (wr) begin
                for (int i = 0; i < 2; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                ref_mem[a] = w;
            end else begin
                exp_rdata = 16'h0000;
                for (int i = 0; i < 2; i++) if (be[i]) exp_rdata[8*i +: 8] = w[8*i +: 8];
            end
        end
        return w;
    endfunction

    task automatic run_txn(input string nm, input logic wr, input logic [AW-1:0] a,
                           input logic [15:0] wd, input logic [1:0] be, input bit junk,
                           input logic [15:0] exp_rd, input bit chk_mem,
                           input logic [15:0] exp_mem);
        int  n, ce, oe, we, we_first, bad, inv, lat;
        bit  seen;
        n = 0; ce = 0; oe = 0; we = 0; we_first = 0; bad = 0; inv = 0; seen = 0;
        lat = exp_latency(wr, be);
        @(negedge Clk);
        Req = 1'b1; Wr = wr; Addr = a; Wdata = wd; Byte_En = be;
        while (!seen && n < 40) begin
            @(negedge Clk);
            n++;
            if (junk) begin
                Req = 1'($urandom); Wr = 1'($urandom); Addr = AW'($urandom);
                Wdata = 16'($urandom); Byte_En = 2'($urandom);
            end else begin
                Req = 1'b0;
            end
            if (!Mem_CE_N) begin
                ce++;
                if (Mem_Addr !== a || Mem_BE_N !== ~be) bad++;
            end
            if (!Mem_OE_N) oe++;
            if (!Mem_WE_N) begin
                we++;
                if (we_first == 0) we_first = n;
                if (mem_data !== wd) bad++;
            end
            if (!Mem_OE_N && !Mem_WE_N) inv++;
            if (Ready) seen = 1'b1;
        end
        Req = 1'b0;
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_ce_cycles"}, ce, (be == 0) ? 0 : (wr ? WWR + 2 : WRD));
        chk({nm, "_oe_cycles"}, oe, (be != 0 && !wr) ? WRD : 0);
        chk({nm, "_we_cycles"}, we, (be != 0 && wr) ? WWR : 0);
        chk({nm, "_we_first"}, we_first, (be != 0 && wr) ? 2 : 0);
        chk({nm, "_addr_be_data"}, bad, 0);
        chk({nm, "_oe_we_overlap"}, inv, 0);
        chk({nm, "_rdata"}, 32'(Rdata), 32'(exp_rd));
        @(negedge Clk);
        chk({nm, "_single_pulse"}, 32'({Ready, Busy}), 32'(2'b00));
        if (chk_mem) chk({nm, "_mem"}, 32'(sram[a[10:0]]), 32'(exp_mem));
    endtask

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        bit          junk;
        logic [15:0] exp_rd;
        bit          chk_mem;
        logic [15:0] exp_mem;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [15:0] em;
        logic        r_wr;
        logic [19:0] r_a;
        logic [15:0] r_wd;
        logic [1:0]  r_be;
        bit          r_junk;
        int          cnt_rdy;

        tests = 0; errors = 0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(11'(i));
        exp_rdata = 16'h0000;
        Reset = 1'b1; Req = 1'b0; Wr = 1'b0; Byte_En = 2'b00;
        Addr = '0; Wdata = '0;

        vt[0] = '{1'b0, 20'h00123, 16'h0000, 2'b11, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
        vt[1] = '{1'b1, 20'h00040, 16'h1234, 2'b11, 1'b0, 16'hBEEF, 1'b1, 16'h1234};
        vt[2] = '{1'b0, 20'h00077, 16'h0000, 2'b10, 1'b0, 16'hAB00, 1'b0, 16'h0000};
        vt[3] = '{1'b1, 20'h00077, 16'h0055, 2'b01, 1'b0, 16'hAB00, 1'b1, 16'hAB55};
        vt[4] = '{1'b0, 20'h00077, 16'h0000, 2'b11, 1'b1, 16'hAB55, 1'b0, 16'h0000};
        vt[5] = '{1'b0, 20'h00040, 16'h0000, 2'b00, 1'b1, 16'hAB55, 1'b0, 16'h0000};
        vt[6] = '{1'b1, 20'h00040, 16'hFFFF, 2'b00, 1'b0, 16'hAB55, 1'b1, 16'h1234};
        vt[7] = '{1'b0, 20'h00040, 16'h0000, 2'b01, 1'b1, 16'h0034, 1'b0, 16'h0000};

        repeat (3) @(negedge Clk);
        chk("reset_strobes", 32'({Busy, Ready, Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_BE_N}),
            32'(7'b00_111_11));
        chk("reset_rdata", 32'(Rdata), 32'h0);
        chk("reset_addr", 32'(Mem_Addr), 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 8; i++) begin
            em = model_apply(vt[i].wr, vt[i].addr[10:0], vt[i].wdata, vt[i].be);
            run_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be,
                    vt[i].junk, vt[i].exp_rd, vt[i].chk_mem, vt[i].exp_mem);
            chk($sformatf("vec%0d_model", i), 32'(exp_rdata), 32'(vt[i].exp_rd));
        end

        // Reset asserted mid-cycle during a read
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b0; Addr = 20'h00123; Byte_En = 2'b11;
        @(negedge Clk);
        Req = 1'b0;
        chk("abort_rd_started", 32'(Mem_OE_N), 32'h0);
        #2 Reset = 1'b1;
        #1;
        chk("abort_rd_strobes", 32'({Busy, Ready, Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_BE_N}),
            32'(7'b00_111_11));
        chk("abort_rd_rdata", 32'(Rdata), 32'h0);
        chk("abort_rd_addr", 32'(Mem_Addr), 32'h0);
        exp_rdata = 16'h0000;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        cnt_rdy = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Ready || Busy) cnt_rdy++;
        end
        chk("abort_rd_no_ready", cnt_rdy, 0);

        // Reset asserted during the write pulse
        @(negedge Clk);
        Req = 1'b1; Wr = 1'b1; Addr = 20'h00500; Wdata = 16'hC3C3; Byte_En = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            Req = 1'b0;
            if (!Mem_WE_N) break;
        end
        chk("abort_wr_pulse_reached", 32'(Mem_WE_N), 32'h0);
        #2 Reset = 1'b1;
        #1;
        chk("abort_wr_strobes", 32'({Busy, Ready, Mem_CE_N, Mem_WE_N}), 32'(4'b0011));
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        cnt_rdy = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Ready) cnt_rdy++;
        end
        chk("abort_wr_no_ready", cnt_rdy, 0);
        em = model_apply(1'b0, 11'h040, 16'h0000, 2'b11);
        run_txn("post_reset_rd", 1'b0, 20'h00040, 16'h0000, 2'b11, 1'b0,
                exp_rdata, 1'b0, 16'h0000);
        chk("post_reset_model", 32'(exp_rdata), 32'h1234);

        // Random traffic against the reference model
        for (int t = 0; t < 80; t++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_a    = 20'($urandom_range(0, 1023));
            r_wd   = 16'($urandom);
            r_be   = 2'($urandom_range(0, 3));
            r_junk = 1'($urandom_range(0, 1));
            em = model_apply(r_wr, r_a[10:0], r_wd, r_be);
            run_txn($sformatf("rnd%0d", t), r_wr, r_a, r_wd, r_be, r_junk,
                    exp_rdata, r_wr, em);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
